regfile_read_port: RTL and testbench
====================================

Name: regfile_read_port

Overview:
- Storage and read side of the 32-entry register file; consumes the one-hot write-select vector from the 5-to-32 write decoder.
- Holds 32 x DATA_W registers and serves two registered read ports with 1-cycle latency.
- Provides write-to-read bypass, hardwires X31 to zero, and flags illegal (non-one-hot) write-select vectors.

Parameters:
- DATA_W, 64, width of each register and of the data ports.
- ZERO_REG, 31, index of the register that always reads zero and is never written.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- wrSel  input  32  write-select vector from the write decoder; expected all-zero or one-hot.
- wrData  input  DATA_W  data written to the selected register.
- rdReq  input  1  read request, sampled on the rising edge.
- readReg1  input  5  read port 1 register address.
- readReg2  input  5  read port 2 register address.
- rdValid  output  1  high for exactly one cycle after each accepted rdReq.
- readData1  output  DATA_W  registered read data, port 1.
- readData2  output  DATA_W  registered read data, port 2.
- wrErr  output  1  sticky flag: a non-one-hot wrSel was seen.

Behaviour:
- Reset (reset=0, asynchronous, takes effect mid-cycle):
  - All 32 registers, readData1, readData2, rdValid and wrErr go to 0 immediately.
  - Outputs hold 0 while reset=0.
  - A read in flight when reset asserts is dropped; no rdValid pulse follows.
- Write, on rising edge:
  - popcount(wrSel)=0: no write.
  - popcount(wrSel)=1 with bit i != ZERO_REG: register i loads wrData.
  - popcount(wrSel)=1 with bit ZERO_REG: no write, no error.
  - popcount(wrSel)>=2: no register written; wrErr set to 1 on that edge.
- wrErr is sticky; only reset clears it.
- Read, on rising edge with rdReq=1:
  - Next cycle: rdValid=1, and readDataN = contents of register readRegN.
  - Latency is exactly 1 clock.
- Read, on rising edge with rdReq=0:
  - rdValid=0 next cycle.
  - readData1/readData2 hold their previous values.
- Back-to-back rdReq on consecutive edges keeps rdValid high continuously, with new data each cycle.
- Bypass (write-first), on an edge with both rdReq=1 and a legal one-hot write to register i != ZERO_REG:
  - Any port with readRegN=i returns the incoming wrData, not the old contents.
- Illegal multi-hot write on the same edge as a read: no bypass; the read returns the old contents.
- readRegN=ZERO_REG always returns 0, including on the same edge as any write.
- Both ports may address the same register; both return identical data.
- No X/Z propagation: every bit of the outputs and storage has a defined reset value.

Test Plan:
- Reset, then rdReq=1 with readReg1=5, readReg2=31 -> one cycle later rdValid=1, readData1=0, readData2=0; next cycle with rdReq=0 -> rdValid=0.
- Write wrSel=32'h0000_0008 with wrData=64'hDEAD_BEEF_0123_4567, then read readReg1=3 -> readData1=64'hDEAD_BEEF_0123_4567 one cycle after the request.
- Same edge: wrSel=32'h0000_0400 with wrData=64'h55, rdReq=1, readReg1=10, readReg2=10 -> both ports return 64'h55 (bypass); a later read of reg 10 still returns 64'h55.
- wrSel=32'h8000_0000 with wrData=64'hFFFF, then read reg 31 -> 0 and wrErr=0.
- wrSel=32'h0000_0006 with wrData=64'h77 -> wrErr=1; regs 1 and 2 unchanged (read 0 after reset); wrErr stays 1 through 10 further legal writes.
- Write reg 7 = 64'h1234, issue rdReq, and pull reset low in the middle of that cycle -> outputs go to 0 at once and no rdValid pulse follows. After reset releases, reading reg 7 returns 0 and wrErr=0.

Source files
------------

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
//
// Storage and read side of the 32-entry register file. Holds 32 x DATA_W
// registers written through a one-hot select vector from the write decoder.
// Two read ports return data one clock after a read request.
//
// Write behaviour:
//   - An all-zero wrSel writes nothing.
//   - A one-hot wrSel writes wrData into the selected register.
//   - Selecting ZERO_REG writes nothing and is not an error.
//   - A multi-hot wrSel writes nothing and sets the sticky wrErr flag.
//
// Read behaviour:
//   - A read on the same edge as a legal write returns the incoming wrData
//     (write-first bypass).
//   - Reading ZERO_REG always returns zero.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous active-low reset (0 = in reset)
//   wrSel      in   32-bit write select, expected all-zero or one-hot
//   wrData     in   DATA_W write data
//   rdReq      in   read request, sampled on the rising edge
//   readReg1   in   5-bit read address, port 1
//   readReg2   in   5-bit read address, port 2
//   rdValid    out  one-cycle pulse following each accepted rdReq
//   readData1  out  registered read data, port 1
//   readData2  out  registered read data, port 2
//   wrErr      out  sticky flag: a non-one-hot wrSel was seen
// -----------------------------------------------------------------------------
module regfile_read_port #(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       wrSel,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdReq,
    input  logic [4:0]        readReg1,
    input  logic [4:0]        readReg2,
    output logic              rdValid,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              wrErr
);

    logic [DATA_W-1:0] r_regs [32];

    logic              w_anyHot;
    logic              w_multiHot;
    logic              w_legal;
    logic [31:0]       w_wrEn;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Clearing the lowest set bit leaves a nonzero value only when two or
    // more bits are set. This detects multi-hot without a full popcount.
    always_comb begin
        w_anyHot   = |wrSel;
        w_multiHot = |(wrSel & (wrSel - 32'd1));
        w_legal    = w_anyHot & ~w_multiHot;
    end

    // Per-register write enables. ZERO_REG is masked off so it stays at its
    // reset value of zero forever.
    always_comb begin
        w_wrEn = '0;
        for (int i = 0; i < 32; i++) begin
            if (i != ZERO_REG) begin
                w_wrEn[i] = w_legal & wrSel[i];
            end
        end
    end

    // Read mux with write-first bypass. A multi-hot write is never bypassed,
    // because it does not update any register.
    always_comb begin
        w_rd1 = r_regs[readReg1];
        w_rd2 = r_regs[readReg2];
        if (w_wrEn[readReg1]) begin
            w_rd1 = wrData;
        end
        if (w_wrEn[readReg2]) begin
            w_rd2 = wrData;
        end
        if (readReg1 == 5'(ZERO_REG)) begin
            w_rd1 = '0;
        end
        if (readReg2 == 5'(ZERO_REG)) begin
            w_rd2 = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_wrEn[i]) begin
                    r_regs[i] <= wrData;
                end
            end
        end
    end

    // Read data holds its previous value when no read is requested.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdValid   <= 1'b0;
            readData1 <= '0;
            readData2 <= '0;
        end else begin
            rdValid <= rdReq;
            if (rdReq) begin
                readData1 <= w_rd1;
                readData2 <= w_rd2;
            end
        end
    end

    // The error flag is sticky: only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrErr <= 1'b0;
        end else if (w_multiHot) begin
            wrErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_port
//
// Self-checking bench for regfile_read_port. Each read request pushes its
// expected port data onto a scoreboard queue. The matching entry is popped
// and compared when rdValid is due one clock later.
// -----------------------------------------------------------------------------
module tb_regfile_read_port;

    localparam int DATA_W = 64;

    logic              clk;
    logic              reset;
    logic [31:0]       wrSel;
    logic [DATA_W-1:0] wrData;
    logic              rdReq;
    logic [4:0]        readReg1;
    logic [4:0]        readReg2;
    logic              rdValid;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              wrErr;

    typedef struct {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checkCount = 0;
    int   passCount  = 0;

    regfile_read_port #(.DATA_W(DATA_W), .ZERO_REG(31)) dut (
        .clk       (clk),
        .reset     (reset),
        .wrSel     (wrSel),
        .wrData    (wrData),
        .rdReq     (rdReq),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .rdValid   (rdValid),
        .readData1 (readData1),
        .readData2 (readData2),
        .wrErr     (wrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a read request and record the data it must return.
    task automatic issueRead(input logic [4:0] a1, input logic [4:0] a2,
                             input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
        exp_t x;
        rdReq    = 1'b1;
        readReg1 = a1;
        readReg2 = a2;
        x.d1     = e1;
        x.d2     = e2;
        sbq.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b0; wrSel = '0; wrData = '0; rdReq = 1'b0; readReg1 = '0; readReg2 = '0;
        tick();
        tick();
        checkCount++;
        if ({rdValid, readData1, readData2, wrErr} !== {1'b0, 64'h0, 64'h0, 1'b0})
            $display("[TB] FAIL reset_state: got v=%b d1=%h d2=%h err=%b, expected all 0",
                     rdValid, readData1, readData2, wrErr);
        else passCount++;
        reset = 1'b1;
        tick();
        issueRead(5'd5, 5'd31, 64'h0, 64'h0);
        tick();
        rdReq = 1'b0;
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL first_read: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
        tick();
        checkCount++;
        if (rdValid !== 1'b0)
            $display("[TB] FAIL idle_valid: got %b, expected 0", rdValid);
        else passCount++;
    endtask

    task automatic test_write_read();
        wrSel = 32'h0000_0008; wrData = 64'hDEAD_BEEF_0123_4567;
        tick();
        wrSel = '0;
        issueRead(5'd3, 5'd0, 64'hDEAD_BEEF_0123_4567, 64'h0);
        tick();
        rdReq = 1'b0;
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL write_read: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
        tick();
        checkCount++;
        if ({rdValid, readData1} !== {1'b0, 64'hDEAD_BEEF_0123_4567})
            $display("[TB] FAIL hold_data: got v=%b d1=%h, expected v=0 d1=deadbeef01234567",
                     rdValid, readData1);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        wrSel = 32'h0000_0400; wrData = 64'h55;
        issueRead(5'd10, 5'd10, 64'h55, 64'h55);
        tick();
        wrSel = '0;
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL bypass: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
        issueRead(5'd10, 5'd3, 64'h55, 64'hDEAD_BEEF_0123_4567);
        tick();
        rdReq = 1'b0;
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL back_to_back: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
    endtask

    task automatic test_zero_reg();
        wrSel = 32'h8000_0000; wrData = 64'hFFFF;
        issueRead(5'd31, 5'd3, 64'h0, 64'hDEAD_BEEF_0123_4567);
        tick();
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL zero_same_edge: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
        wrSel = '0;
        issueRead(5'd31, 5'd31, 64'h0, 64'h0);
        tick();
        rdReq = 1'b0;
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL zero_read: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
        checkCount++;
        if (wrErr !== 1'b0)
            $display("[TB] FAIL zero_no_err: got wrErr=%b, expected 0", wrErr);
        else passCount++;
    endtask

    task automatic test_multi_hot();
        wrSel = 32'h0000_0006; wrData = 64'h77;
        issueRead(5'd1, 5'd2, 64'h0, 64'h0);
        tick();
        rdReq = 1'b0;
        wrSel = '0;
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL multi_no_bypass: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
        checkCount++;
        if (wrErr !== 1'b1)
            $display("[TB] FAIL multi_err: got wrErr=%b, expected 1", wrErr);
        else passCount++;
        for (int i = 0; i < 10; i++) begin
            wrSel  = 32'd1 << (i + 11);
            wrData = 64'(i + 100);
            tick();
        end
        wrSel = '0;
        checkCount++;
        if (wrErr !== 1'b1)
            $display("[TB] FAIL err_sticky: got wrErr=%b, expected 1", wrErr);
        else passCount++;
        issueRead(5'd1, 5'd2, 64'h0, 64'h0);
        tick();
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL multi_unchanged: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
        issueRead(5'd11, 5'd20, 64'd100, 64'd109);
        tick();
        rdReq = 1'b0;
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL legal_writes: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
    endtask

    task automatic test_reset_mid_read();
        wrSel = 32'h0000_0080; wrData = 64'h1234;
        tick();
        wrSel    = '0;
        rdReq    = 1'b1;
        readReg1 = 5'd7;
        readReg2 = 5'd10;
        #3;
        reset = 1'b0;
        #1;
        checkCount++;
        if ({rdValid, readData1, readData2, wrErr} !== {1'b0, 64'h0, 64'h0, 1'b0})
            $display("[TB] FAIL async_reset: got v=%b d1=%h d2=%h err=%b, expected all 0",
                     rdValid, readData1, readData2, wrErr);
        else passCount++;
        tick();
        checkCount++;
        if (rdValid !== 1'b0)
            $display("[TB] FAIL dropped_read: got rdValid=%b, expected 0", rdValid);
        else passCount++;
        rdReq = 1'b0;
        reset = 1'b1;
        tick();
        checkCount++;
        if (rdValid !== 1'b0)
            $display("[TB] FAIL post_reset_valid: got rdValid=%b, expected 0", rdValid);
        else passCount++;
        issueRead(5'd7, 5'd10, 64'h0, 64'h0);
        tick();
        rdReq = 1'b0;
        e = sbq.pop_front();
        checkCount++;
        if ({rdValid, readData1, readData2} !== {1'b1, e.d1, e.d2})
            $display("[TB] FAIL regs_cleared: got v=%b d1=%h d2=%h, expected v=1 d1=%h d2=%h",
                     rdValid, readData1, readData2, e.d1, e.d2);
        else passCount++;
        checkCount++;
        if (wrErr !== 1'b0)
            $display("[TB] FAIL err_cleared: got wrErr=%b, expected 0", wrErr);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_zero_reg();
        test_multi_hot();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
